rfs_ocm_stream_writer: RTL and testbench
========================================

RFS_OCM_STREAM_WRITER -- requirements
Module: rfs_ocm_stream_writer

Interface
REQ-001 Parameter DEPTH, default 37500, words in the target on-chip memory.
REQ-002 Parameter ADDR_W, default 16, word-address width.
REQ-003 Parameter FIFO_DEPTH, default 4, input-buffer entries; power of two, minimum 2.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a capture.
REQ-007 stop  in  1  one-cycle pulse that ends a capture early; the block drains the FIFO first.
REQ-008 cfg_base  in  ADDR_W  first word address of the capture; sampled on an accepted start.
REQ-009 cfg_len  in  ADDR_W  capture length in words; sampled on an accepted start.
REQ-010 in_valid / in_data / in_ready  in / in / out  1 / 32 / 1  sample stream sink.
REQ-011 avm_address  out  ADDR_W  word address to the memory slave.
REQ-012 avm_chipselect, avm_write  out  1  write strobes to the memory slave.
REQ-013 avm_byteenable  out  4  byte enables to the memory slave.
REQ-014 avm_writedata  out  32  write data to the memory slave.
REQ-015 avm_waitrequest  in  1  slave stall.
REQ-016 busy  out  1  high while the capture is not idle.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 cfg_err  out  1  one-cycle pulse when a start is rejected.
REQ-019 wr_count  out  ADDR_W  words committed to memory in the current or last capture.

Function
REQ-020 States: IDLE, RUN, DRAIN, DONE; DONE lasts exactly one cycle and asserts done, then goes to IDLE.
REQ-021 A start in IDLE is rejected (cfg_err pulse, stay IDLE) if cfg_len==0 or cfg_base+cfg_len > DEPTH, computed at ADDR_W+1 bits.
REQ-022 An accepted start latches cfg_base and cfg_len, clears wr_count and the FIFO, and enters RUN.
REQ-023 start is ignored outside IDLE; stop is ignored in IDLE and DONE.
REQ-024 in_ready = (state==RUN) && FIFO not full && (words pushed < cfg_len, one-shot mode only); a push occurs on in_valid && in_ready.
REQ-025 A write is issued whenever the FIFO is non-empty in RUN or DRAIN: avm_write = avm_chipselect = 1, avm_byteenable = 4'hF, avm_writedata = FIFO head, avm_address = base + offset.
REQ-026 While avm_waitrequest is high, the address and data of a pending write remain stable; the write is accepted on avm_write && !avm_waitrequest, which pops the FIFO and increments offset and wr_count.
REQ-027 With no stall, sustained throughput is one word per clock; a simultaneous push and pop leaves the FIFO occupancy unchanged.
REQ-028 Latency: a sample pushed into an empty FIFO appears on the Avalon bus on the next cycle.
REQ-029 One-shot mode: when wr_count reaches cfg_len, the block goes to DONE on the following cycle.
REQ-030 stop in RUN deasserts in_ready and enters DRAIN; DRAIN goes to DONE once the FIFO is empty and no write is pending.
REQ-031 wr_count saturates at 2^ADDR_W-1.

Reset
REQ-032 While reset_n is low: state = IDLE, FIFO is emptied, and in_ready, avm_write, avm_chipselect, busy, done, cfg_err, wr_count and avm_address = 0; avm_byteenable = 4'hF; avm_writedata = 0.
REQ-033 A reset in the middle of a write abandons that write without retry; the memory contents are undefined for that word.

Configuration
REQ-034 Macro RFS_OCM_WRAP_EN defined: circular mode; offset wraps to 0 after cfg_len-1, in_ready ignores the length limit, the capture ends only via stop, and wr_count counts total writes.
REQ-035 Macro RFS_OCM_WRAP_EN undefined: one-shot mode per REQ-024 and REQ-029; the wrap logic is absent.

Verification
REQ-036 base=100, len=3, stream A,B,C, no stall -> writes to addresses 100,101,102 on consecutive cycles; done pulses one cycle later; wr_count=3.
REQ-037 base=37499, len=2 -> cfg_err pulse, busy stays low, no writes; len=0 also gives cfg_err.
REQ-038 waitrequest held high for 5 cycles on the 2nd write with in_valid held high -> address and data stable, in_ready low once 4 samples are buffered, no sample lost or duplicated.
REQ-039 RFS_OCM_WRAP_EN, base=10, len=4, 6 samples then stop -> addresses 10,11,12,13,10,11; DRAIN then done; wr_count=6.
REQ-040 reset_n low while the FIFO holds 3 entries -> all outputs at reset values immediately; after release, a new start works normally.
REQ-041 Without RFS_OCM_WRAP_EN, len=8, stop after 2 accepted samples -> exactly 2 writes, then done.

Source files
------------

// File: rtl/rfs_ocm_stream_writer_if.sv
// +----------------------------------------------------------------------------+
// | Module      : rfs_ocm_stream_writer_if                                     |
// | Description : Sample-stream sink and Avalon-MM write master bundle.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface rfs_ocm_stream_writer_if #(
  parameter int ADDR_W = 16
) ();
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;

  // master: the writer block (sinks the stream, masters the memory bus)
  modport master (
    input  in_valid, in_data, avm_waitrequest,
    output in_ready, avm_address, avm_chipselect, avm_write,
           avm_byteenable, avm_writedata
  );

  // slave: the environment (stream source and memory slave)
  modport slave (
    output in_valid, in_data, avm_waitrequest,
    input  in_ready, avm_address, avm_chipselect, avm_write,
           avm_byteenable, avm_writedata
  );
endinterface

`default_nettype wire

// File: rtl/rfs_ocm_stream_writer.sv
// +----------------------------------------------------------------------------+
// | Module      : rfs_ocm_stream_writer                                        |
// | Description : Buffers a 32-bit sample stream and writes it into on-chip    |
// |               memory; macro RFS_OCM_WRAP_EN selects circular capture.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module rfs_ocm_stream_writer #(
  parameter int DEPTH      = 37500,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [ADDR_W-1:0]      cfg_base_i,
  input  logic [ADDR_W-1:0]      cfg_len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   cfg_err_o,
  output logic [ADDR_W-1:0]      wr_count_o,
  rfs_ocm_stream_writer_if.master bus
);

  localparam int              c_ptr_w     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_ptr_w:0] c_fifo_full = (c_ptr_w + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] c_depth     = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, len_q, offset_q, offset_d, wr_count_q;
  logic               cfg_err_q, cfg_err_d, start_ok_d;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_ptr_w:0]   cnt_q;
`ifndef RFS_OCM_WRAP_EN
  logic [ADDR_W-1:0]  pushed_q;
`endif

  logic              w_in_ready, w_push, w_write, w_accept, w_last, w_cfg_bad;
  logic [ADDR_W:0]   w_cfg_sum;
  logic [ADDR_W-1:0] w_offset_inc;

  always_comb begin
    w_write      = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (cnt_q != '0);
    w_accept     = w_write && !bus.avm_waitrequest;
    w_offset_inc = offset_q + ADDR_W'(1);
    w_cfg_sum    = {1'b0, cfg_base_i} + {1'b0, cfg_len_i};
    w_cfg_bad    = (cfg_len_i == '0) || (w_cfg_sum > c_depth);
`ifdef RFS_OCM_WRAP_EN
    w_in_ready = (state_q == S_RUN) && !stop_i && (cnt_q != c_fifo_full);
    w_last     = 1'b0;
    offset_d   = (offset_q == len_q - ADDR_W'(1)) ? '0 : w_offset_inc;
`else
    w_in_ready = (state_q == S_RUN) && !stop_i && (cnt_q != c_fifo_full) &&
                 (pushed_q < len_q);
    w_last     = w_accept && (w_offset_inc == len_q);
    offset_d   = w_offset_inc;
`endif
    w_push = bus.in_valid && w_in_ready;
  end

  always_comb begin
    state_d    = state_q;
    start_ok_d = 1'b0;
    cfg_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (w_cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            start_ok_d = 1'b1;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_last)      state_d = S_DONE;
        else if (stop_i) state_d = S_DRAIN;
      end
      // Look ahead at the accept so the last write does not cost an extra cycle
      S_DRAIN: begin
        if (w_last || (cnt_q == '0) || ((cnt_q == (c_ptr_w + 1)'(1)) && w_accept))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cfg_err_q  <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      offset_q   <= '0;
      wr_count_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
`ifndef RFS_OCM_WRAP_EN
      pushed_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
      if (start_ok_d) begin
        base_q     <= cfg_base_i;
        len_q      <= cfg_len_i;
        offset_q   <= '0;
        wr_count_q <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
`ifndef RFS_OCM_WRAP_EN
        pushed_q   <= '0;
`endif
      end else begin
        if (w_push) begin
          wr_ptr_q <= wr_ptr_q + c_ptr_w'(1);
`ifndef RFS_OCM_WRAP_EN
          pushed_q <= pushed_q + ADDR_W'(1);
`endif
        end
        if (w_accept) begin
          rd_ptr_q <= rd_ptr_q + c_ptr_w'(1);
          offset_q <= offset_d;
          if (wr_count_q != '1) wr_count_q <= wr_count_q + ADDR_W'(1);
        end
        if (w_push && !w_accept)      cnt_q <= cnt_q + (c_ptr_w + 1)'(1);
        else if (!w_push && w_accept) cnt_q <= cnt_q - (c_ptr_w + 1)'(1);
      end
    end
  end

  // Storage needs no reset: the occupancy counter guards every read
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.avm_write      = w_write;
  assign bus.avm_chipselect = w_write;
  assign bus.avm_byteenable = 4'hF;
  assign bus.avm_writedata  = w_write ? mem_q[rd_ptr_q] : '0;
  assign bus.avm_address    = w_write ? (base_q + offset_q) : '0;
  assign busy_o             = (state_q != S_IDLE);
  assign done_o             = (state_q == S_DONE);
  assign cfg_err_o          = cfg_err_q;
  assign wr_count_o         = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_rfs_ocm_stream_writer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_rfs_ocm_stream_writer                                     |
// | Description : Directed self-checking bench for rfs_ocm_stream_writer.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rfs_ocm_stream_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop;
  logic [15:0] cfg_base, cfg_len;
  logic        busy, done, cfg_err;
  logic [15:0] wr_count;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  logic [15:0] q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];

  rfs_ocm_stream_writer_if #(.ADDR_W(16)) bus ();

  rfs_ocm_stream_writer #(.DEPTH(37500), .ADDR_W(16), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (start),
    .stop_i     (stop),
    .cfg_base_i (cfg_base),
    .cfg_len_i  (cfg_len),
    .busy_o     (busy),
    .done_o     (done),
    .cfg_err_o  (cfg_err),
    .wr_count_o (wr_count),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Writes that the slave accepts at the coming rising edge
  always @(negedge clk) begin
    if (reset_n && bus.avm_write && !bus.avm_waitrequest) begin
      q_addr.push_back(bus.avm_address);
      q_data.push_back(bus.avm_writedata);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    cfg_base = b;
    cfg_len  = l;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  initial begin
    logic seen;
    logic push;
    int   npush;

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_base = '0; cfg_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.avm_waitrequest = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_write", bus.avm_write, 0);
    check("rst_cs", bus.avm_chipselect, 0);
    check("rst_addr", bus.avm_address, 0);
    check("rst_be", bus.avm_byteenable, 4'hF);
    check("rst_wdata", bus.avm_writedata, 0);
    reset_n = 1'b1;
    tick();

    // Rejected configurations: end past DEPTH, and zero length
    do_start(16'd37499, 16'd2);
    @(negedge clk);
    check("rej_cfg_err", cfg_err, 1);
    check("rej_busy", busy, 0);
    tick();
    @(negedge clk);
    check("rej_cfg_err_pulse", cfg_err, 0);
    do_start(16'd0, 16'd0);
    @(negedge clk);
    check("rej0_cfg_err", cfg_err, 1);
    check("rej0_busy", busy, 0);
    check("rej_no_writes", q_addr.size(), 0);
    tick();

`ifdef RFS_OCM_WRAP_EN
    // Circular capture: base 10, len 4, 6 samples then stop
    clear_q();
    do_start(16'd10, 16'd4);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = 32'h100 + i;
      tick();
    end
    bus.in_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(20, seen);
    check("wrap_done_seen", seen, 1);
    check("wrap_wr_count", wr_count, 6);
    check("wrap_nwrites", q_addr.size(), 6);
    for (int i = 0; i < 6 && i < q_addr.size(); i++) begin
      check($sformatf("wrap_addr%0d", i), q_addr[i], 10 + (i % 4));
      check($sformatf("wrap_data%0d", i), q_data[i], 32'h100 + i);
    end
    tick();
`else
    // base 100, len 3, stream A,B,C with no stall
    clear_q();
    do_start(16'd100, 16'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA;
    @(negedge clk);
    check("os_in_ready", bus.in_ready, 1);
    check("os_busy", busy, 1);
    tick(); bus.in_data = 32'hB;
    tick(); bus.in_data = 32'hC;
    tick(); bus.in_valid = 1'b0;
    @(negedge clk);
    check("os_last_write", bus.avm_write, 1);
    check("os_last_addr", bus.avm_address, 102);
    check("os_last_data", bus.avm_writedata, 32'hC);
    check("os_done_early", done, 0);
    tick();
    @(negedge clk);
    check("os_done", done, 1);
    check("os_wr_count", wr_count, 3);
    check("os_in_ready_done", bus.in_ready, 0);
    tick();
    @(negedge clk);
    check("os_done_pulse", done, 0);
    check("os_idle", busy, 0);
    check("os_nwrites", q_addr.size(), 3);
    for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
      check($sformatf("os_addr%0d", i), q_addr[i], 100 + i);
      check($sformatf("os_data%0d", i), q_data[i], 32'hA + i);
    end
    if (q_cyc.size() == 3) begin
      check("os_consec01", q_cyc[1] - q_cyc[0], 1);
      check("os_consec12", q_cyc[2] - q_cyc[1], 1);
    end
    tick();

    // 5-cycle stall on the second write with in_valid held high
    clear_q();
    do_start(16'd200, 16'd10);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h5000;
    npush = 0;
    seen  = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      bus.avm_waitrequest = (k >= 2 && k <= 6);
      @(negedge clk);
      if (k >= 2 && k <= 6) begin
        check($sformatf("st_addr_k%0d", k), bus.avm_address, 201);
        check($sformatf("st_data_k%0d", k), bus.avm_writedata, 32'h5001);
      end
      if (k == 4) check("st_ready_k4", bus.in_ready, 1);
      if (k == 5) check("st_ready_full_k5", bus.in_ready, 0);
      if (k == 7) check("st_ready_full_k7", bus.in_ready, 0);
      if (done) seen = 1'b1;
      push = bus.in_valid && bus.in_ready;
      tick();
      if (push) begin
        npush++;
        bus.in_data = 32'h5000 + npush;
        if (npush == 10) bus.in_valid = 1'b0;
      end
    end
    bus.avm_waitrequest = 1'b0;
    check("st_done_seen", seen, 1);
    check("st_wr_count", wr_count, 10);
    check("st_nwrites", q_addr.size(), 10);
    for (int i = 0; i < 10 && i < q_addr.size(); i++) begin
      check($sformatf("st_addr%0d", i), q_addr[i], 200 + i);
      check($sformatf("st_data%0d", i), q_data[i], 32'h5000 + i);
    end
    tick();

    // Early stop after 2 samples; capture ends exactly at DEPTH
    clear_q();
    do_start(16'd37492, 16'd8);
    @(negedge clk);
    check("sp_accepted", busy, 1);
    tick();
    bus.in_valid = 1'b1; bus.in_data = 32'h77;
    tick(); bus.in_data = 32'h78;
    tick(); bus.in_valid = 1'b0; stop = 1'b1;
    @(negedge clk);
    check("sp_ready_on_stop", bus.in_ready, 0);
    tick();
    stop = 1'b0;
    wait_done(20, seen);
    check("sp_done_seen", seen, 1);
    check("sp_wr_count", wr_count, 2);
    check("sp_nwrites", q_addr.size(), 2);
    for (int i = 0; i < 2 && i < q_addr.size(); i++) begin
      check($sformatf("sp_addr%0d", i), q_addr[i], 37492 + i);
      check($sformatf("sp_data%0d", i), q_data[i], 32'h77 + i);
    end
    tick();

    // Reset while three entries are buffered behind a stalled slave
    clear_q();
    do_start(16'd300, 16'd10);
    bus.avm_waitrequest = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 32'h900 + i;
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("mr_pending", bus.avm_write, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_write", bus.avm_write, 0);
    check("mr_cs", bus.avm_chipselect, 0);
    check("mr_addr", bus.avm_address, 0);
    check("mr_wdata", bus.avm_writedata, 0);
    check("mr_in_ready", bus.in_ready, 0);
    check("mr_wr_count", wr_count, 0);
    check("mr_be", bus.avm_byteenable, 4'hF);
    @(negedge clk);
    reset_n = 1'b1;
    bus.avm_waitrequest = 1'b0;
    tick();
    do_start(16'd5, 16'd1);
    bus.in_valid = 1'b1; bus.in_data = 32'h55;
    tick();
    bus.in_valid = 1'b0;
    wait_done(20, seen);
    check("mr_done_seen", seen, 1);
    check("mr_new_wr_count", wr_count, 1);
    check("mr_nwrites", q_addr.size(), 1);
    if (q_addr.size() == 1) begin
      check("mr_new_addr", q_addr[0], 5);
      check("mr_new_data", q_data[0], 32'h55);
    end
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
